// File: rtl/kr580_pkg.sv
// Shared definitions for KR580 port-mapped peripherals: register offsets,
// control/status bit positions and the timer load helper.
package kr580_pkg;

    localparam logic [1:0] OFS_RLO  = 2'd0;
    localparam logic [1:0] OFS_RHI  = 2'd1;
    localparam logic [1:0] OFS_CTRL = 2'd2;
    localparam logic [1:0] OFS_STAT = 2'd3;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_AUTO  = 1;
    localparam int CTRL_IE    = 2;
    localparam int CTRL_LATCH = 7;

    localparam int STAT_PEND = 0;
    localparam int STAT_RUN  = 1;

    // A reload of zero stands for the full 65536-tick period.
    function automatic logic [16:0] load_count(input logic [15:0] reload);
        return (reload == 16'd0) ? 17'h10000 : {1'b0, reload};
    endfunction

endpackage

// File: rtl/kr580_port_decode.sv
// Decodes a block of four CPU I/O ports: one write strobe per register on the
// rising edge of the port-write level, plus the read select for the port-in mux.
import kr580_pkg::*;

module kr580_port_decode #(
    parameter logic [7:0] BASE_PORT = 8'h40
) (
    input  logic [7:0] pin_pa,
    input  logic       pin_pw,
    input  logic       pw_q,
    output logic       wr_rlo,
    output logic       wr_rhi,
    output logic       wr_ctrl,
    output logic       wr_stat,
    output logic       rd_hit,
    output logic [1:0] rd_sel
);

    logic [7:0] ofs;
    logic       wr_edge;

    // Offset arithmetic keeps the decode correct for unaligned base ports.
    always_comb begin
        ofs     = pin_pa - BASE_PORT;
        rd_hit  = (ofs < 8'd4);
        rd_sel  = ofs[1:0];
        wr_edge = pin_pw & ~pw_q & rd_hit;
        wr_rlo  = wr_edge && (rd_sel == OFS_RLO);
        wr_rhi  = wr_edge && (rd_sel == OFS_RHI);
        wr_ctrl = wr_edge && (rd_sel == OFS_CTRL);
        wr_stat = wr_edge && (rd_sel == OFS_STAT);
    end

endmodule

// File: rtl/kr580_port_timer.sv
// Port-mapped interval timer for the KR580 CPU: 16-bit reload, prescaled tick,
// one-shot or auto-reload, pending flag and level interrupt request.
import kr580_pkg::*;

module kr580_port_timer #(
    parameter logic [7:0] BASE_PORT = 8'h40,
    parameter int         PRESCALE  = 25000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] pin_pa,
    input  logic [7:0] pin_po,
    input  logic       pin_pw,
    output logic [7:0] pin_pi,
    output logic       pin_intr
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic          pw_q, pw_d;
    logic [15:0]   reload_q, reload_d;
    logic [15:0]   snap_q, snap_d;
    logic [16:0]   cnt_q, cnt_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          en_q, en_d;
    logic          auto_q, auto_d;
    logic          ie_q, ie_d;
    logic          pend_q, pend_d;
    logic [7:0]    pi_q, pi_d;
    logic          intr_q, intr_d;

    logic          wr_rlo, wr_rhi, wr_ctrl, wr_stat, rd_hit;
    logic [1:0]    rd_sel;
    logic          tick, stop;

    kr580_port_decode #(.BASE_PORT(BASE_PORT)) u_decode (
        .pin_pa  (pin_pa),
        .pin_pw  (pin_pw),
        .pw_q    (pw_q),
        .wr_rlo  (wr_rlo),
        .wr_rhi  (wr_rhi),
        .wr_ctrl (wr_ctrl),
        .wr_stat (wr_stat),
        .rd_hit  (rd_hit),
        .rd_sel  (rd_sel)
    );

    always_comb begin
        pw_d     = pin_pw;
        reload_d = reload_q;
        snap_d   = snap_q;
        cnt_d    = cnt_q;
        en_d     = en_q;
        auto_d   = auto_q;
        ie_d     = ie_q;
        pend_d   = pend_q;
        tick     = en_q && (pre_q == PRE_MAX);
        // A ctrl write that clears EN beats a coincident tick.
        stop     = wr_ctrl && !pin_po[CTRL_LATCH] && !pin_po[CTRL_EN];
        pre_d    = en_q ? (tick ? '0 : pre_q + 1'b1) : '0;

        if (wr_stat) pend_d = 1'b0;

        // Expiry is processed after the ack so a coincident set wins.
        if (tick && !stop) begin
            cnt_d = cnt_q - 17'd1;
            if (cnt_q == 17'd1) begin
                pend_d = 1'b1;
                if (auto_q) cnt_d = load_count(reload_q);
                else        en_d  = 1'b0;
            end
        end

        if (wr_rlo) reload_d[7:0]  = pin_po;
        if (wr_rhi) reload_d[15:8] = pin_po;

        if (wr_ctrl) begin
            if (pin_po[CTRL_LATCH]) begin
                snap_d = cnt_q[15:0];
            end else begin
                en_d   = pin_po[CTRL_EN];
                auto_d = pin_po[CTRL_AUTO];
                ie_d   = pin_po[CTRL_IE];
                if (pin_po[CTRL_EN] && !en_q) begin
                    cnt_d = load_count(reload_q);
                    pre_d = '0;
                end
            end
        end

        pi_d = 8'h00;
        if (rd_hit) begin
            case (rd_sel)
                OFS_RLO:  pi_d = snap_q[7:0];
                OFS_RHI:  pi_d = snap_q[15:8];
                OFS_CTRL: pi_d = {5'b0, ie_q, auto_q, en_q};
                default: begin
                    pi_d[STAT_PEND] = pend_q;
                    pi_d[STAT_RUN]  = en_q;
                end
            endcase
        end

        intr_d = pend_q & ie_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pw_q     <= 1'b0;
            reload_q <= '0;
            snap_q   <= '0;
            cnt_q    <= '0;
            pre_q    <= '0;
            en_q     <= 1'b0;
            auto_q   <= 1'b0;
            ie_q     <= 1'b0;
            pend_q   <= 1'b0;
            pi_q     <= '0;
            intr_q   <= 1'b0;
        end else begin
            pw_q     <= pw_d;
            reload_q <= reload_d;
            snap_q   <= snap_d;
            cnt_q    <= cnt_d;
            pre_q    <= pre_d;
            en_q     <= en_d;
            auto_q   <= auto_d;
            ie_q     <= ie_d;
            pend_q   <= pend_d;
            pi_q     <= pi_d;
            intr_q   <= intr_d;
        end
    end

    assign pin_pi   = pi_q;
    assign pin_intr = intr_q;

endmodule

// File: tb/tb_kr580_port_timer.sv
// Bench for kr580_port_timer: directed scenarios plus random port traffic
// against a tick-arithmetic reference model.
module tb_kr580_port_timer;

    localparam int         P    = 4;
    localparam logic [7:0] BASE = 8'h40;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [7:0] pin_pa = 8'h00;
    logic [7:0] pin_po = 8'h00;
    logic       pin_pw = 1'b0;
    logic [7:0] pin_pi;
    logic       pin_intr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    kr580_port_timer #(.BASE_PORT(BASE), .PRESCALE(P)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pin_pa   (pin_pa),
        .pin_po   (pin_po),
        .pin_pw   (pin_pw),
        .pin_pi   (pin_pi),
        .pin_intr (pin_intr)
    );

    // Reference model: ticks are every P-th clock since start, m_left counts
    // remaining ticks of the current period.
    logic        m_pw;
    bit          m_en, m_auto, m_ie, m_pend;
    logic [15:0] m_reload, m_snap;
    logic [16:0] m_left;
    int          m_cyc;
    logic [7:0]  m_pi;
    logic        m_intr;

    task automatic model_reset();
        m_pw = 0; m_en = 0; m_auto = 0; m_ie = 0; m_pend = 0;
        m_reload = 0; m_snap = 0; m_left = 0; m_cyc = 0; m_pi = 0; m_intr = 0;
    endtask

    task automatic model_edge();
        int ofs;
        bit hit, wr, tick, en_old;
        ofs = int'(pin_pa) - int'(BASE);
        hit = (ofs >= 0) && (ofs < 4);
        wr  = pin_pw && !m_pw && hit;
        m_pi = 8'h00;
        if (hit) begin
            case (ofs)
                0: m_pi = m_snap[7:0];
                1: m_pi = m_snap[15:8];
                2: m_pi = {5'b0, m_ie, m_auto, m_en};
                default: m_pi = {6'b0, m_en, m_pend};
            endcase
        end
        m_intr = m_pend && m_ie;
        m_pw   = pin_pw;
        en_old = m_en;
        tick   = 0;
        if (m_en) begin
            m_cyc++;
            tick = (m_cyc % P) == 0;
        end
        if (wr && ofs == 2 && !pin_po[7] && !pin_po[0]) tick = 0;
        if (wr && ofs == 2 && pin_po[7]) m_snap = m_left[15:0];
        if (wr && ofs == 3) m_pend = 0;
        if (tick) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_pend = 1;
                if (m_auto) m_left = (m_reload == 0) ? 17'd65536 : {1'b0, m_reload};
                else m_en = 0;
            end
        end
        if (wr && ofs == 0) m_reload[7:0]  = pin_po;
        if (wr && ofs == 1) m_reload[15:8] = pin_po;
        if (wr && ofs == 2 && !pin_po[7]) begin
            if (pin_po[0] && !en_old) begin
                m_left = (m_reload == 0) ? 17'd65536 : {1'b0, m_reload};
                m_cyc  = 0;
            end
            m_en   = pin_po[0];
            m_auto = pin_po[1];
            m_ie   = pin_po[2];
        end
    endtask

    task automatic step();
        if (rst_n) model_edge();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        pin_pa = a; pin_po = d; pin_pw = 1'b1;
        step();
        pin_pw = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        step(); step();
        checks++;
        if (pin_intr !== 1'b0) begin
            failures++; $display("FAIL reset_intr got=%b exp=0", pin_intr);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pin_pa = BASE + 8'(i);
            step();
            checks++;
            if (pin_pi !== 8'h00) begin
                failures++; $display("FAIL reset_read port=%h got=%h exp=00", pin_pa, pin_pi);
            end
        end
    endtask

    task automatic test_auto_reload();
        int t0, r1, r2, r3, n;
        wr(8'h40, 8'h03); wr(8'h41, 8'h00);
        pin_pa = 8'h42; pin_po = 8'h07; pin_pw = 1'b1;
        step();
        t0 = cyc; pin_pw = 1'b0;
        n = 0;
        while (pin_intr !== 1'b1 && n < 40) begin
            step(); n++;
            checks++;
            if (pin_intr !== m_intr) begin
                failures++; $display("FAIL auto_track cyc=%0d got=%b exp=%b", cyc, pin_intr, m_intr);
            end
        end
        r1 = cyc;
        checks++;
        if (r1 - t0 !== 13) begin
            failures++; $display("FAIL auto_first latency got=%0d exp=13", r1 - t0);
        end
        wr(8'h43, 8'h5A);
        checks++;
        if (pin_intr !== 1'b0) begin
            failures++; $display("FAIL auto_ack got=%b exp=0", pin_intr);
        end
        n = 0;
        while (pin_intr !== 1'b1 && n < 40) begin step(); n++; end
        r2 = cyc;
        wr(8'h43, 8'h00);
        n = 0;
        while (pin_intr !== 1'b1 && n < 40) begin step(); n++; end
        r3 = cyc;
        checks++;
        if (r2 - r1 !== 12 || r3 - r2 !== 12) begin
            failures++; $display("FAIL auto_period got=%0d,%0d exp=12,12", r2 - r1, r3 - r2);
        end
    endtask

    task automatic test_one_shot();
        int t0, n;
        wr(8'h42, 8'h00); wr(8'h43, 8'h00);
        wr(8'h40, 8'h02); wr(8'h41, 8'h00);
        pin_pa = 8'h42; pin_po = 8'h05; pin_pw = 1'b1;
        step();
        t0 = cyc; pin_pw = 1'b0;
        n = 0;
        while (pin_intr !== 1'b1 && n < 40) begin step(); n++; end
        checks++;
        if (cyc - t0 !== 9) begin
            failures++; $display("FAIL oneshot_latency got=%0d exp=9", cyc - t0);
        end
        pin_pa = 8'h43;
        step();
        checks++;
        if (pin_pi !== 8'h01) begin
            failures++; $display("FAIL oneshot_stat got=%h exp=01", pin_pi);
        end
        wr(8'h43, 8'h00);
        for (int i = 0; i < 30; i++) begin
            step();
            checks++;
            if (pin_intr !== 1'b0 || pin_pi !== 8'h00) begin
                failures++; $display("FAIL oneshot_quiet i=%0d intr=%b pi=%h exp 0/00", i, pin_intr, pin_pi);
            end
        end
    endtask

    task automatic test_hold_pw();
        logic [7:0] prev;
        wr(8'h42, 8'h00); wr(8'h43, 8'h00);
        wr(8'h40, 8'h10); wr(8'h41, 8'h00);
        pin_pa = 8'h42; pin_po = 8'h01; pin_pw = 1'b1;
        repeat (6) step();
        pin_pw = 1'b0;
        step();
        prev = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            wr(8'h42, 8'h80);
            pin_pa = 8'h40;
            step();
            checks++;
            if (pin_pi !== m_pi || (k == 0 && pin_pi !== 8'h0F)) begin
                failures++; $display("FAIL hold_snap_lo k=%0d got=%h exp=%h", k, pin_pi, (k == 0) ? 8'h0F : m_pi);
            end
            checks++;
            if (!(pin_pi < prev)) begin
                failures++; $display("FAIL hold_monotonic k=%0d got=%h prev=%h", k, pin_pi, prev);
            end
            prev = pin_pi;
            pin_pa = 8'h41;
            step();
            checks++;
            if (pin_pi !== 8'h00) begin
                failures++; $display("FAIL hold_snap_hi k=%0d got=%h exp=00", k, pin_pi);
            end
            repeat (5) step();
        end
    endtask

    task automatic test_ack_on_expiry();
        wr(8'h42, 8'h00); wr(8'h43, 8'h00);
        wr(8'h40, 8'h02); wr(8'h41, 8'h00);
        pin_pa = 8'h42; pin_po = 8'h07; pin_pw = 1'b1;
        step();
        pin_pw = 1'b0;
        repeat (7) step();
        pin_pa = 8'h43; pin_pw = 1'b1;
        step();
        pin_pw = 1'b0;
        step();
        checks++;
        if (pin_intr !== 1'b1) begin
            failures++; $display("FAIL ack_expiry_intr got=%b exp=1", pin_intr);
        end
        step();
        checks++;
        if (pin_pi !== 8'h03 || pin_intr !== 1'b1) begin
            failures++; $display("FAIL ack_expiry_stat pi=%h intr=%b exp=03/1", pin_pi, pin_intr);
        end
    endtask

    task automatic test_random();
        logic [7:0] a;
        for (int i = 0; i < 800; i++) begin
            if (pin_pw) pin_pw = 1'b0;
            else if ($urandom_range(0, 3) == 0) pin_pw = 1'b1;
            a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : BASE + 8'($urandom_range(0, 3));
            pin_pa = a;
            case (a)
                8'h40: pin_po = 8'($urandom_range(0, 5));
                8'h41: pin_po = ($urandom_range(0, 9) == 0) ? 8'h01 : 8'h00;
                8'h42: pin_po = ($urandom_range(0, 4) == 0) ? 8'h80 : 8'($urandom_range(0, 7));
                default: pin_po = 8'($urandom);
            endcase
            step();
            checks++;
            if (pin_pi !== m_pi || pin_intr !== m_intr) begin
                failures++;
                $display("FAIL random i=%0d pi=%h/%h intr=%b/%b (got/exp)", i, pin_pi, m_pi, pin_intr, m_intr);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        wr(8'h43, 8'h00); wr(8'h42, 8'h00);
        wr(8'h40, 8'h03); wr(8'h41, 8'h00); wr(8'h42, 8'h07);
        n = 0;
        while (pin_intr !== 1'b1 && n < 40) begin step(); n++; end
        repeat (2) step();
        checks++;
        if (pin_intr !== 1'b1) begin
            failures++; $display("FAIL resetmid_pre got=%b exp=1", pin_intr);
        end
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (pin_intr !== 1'b0) begin
            failures++; $display("FAIL resetmid_async got=%b exp=0", pin_intr);
        end
        model_reset();
        step(); step();
        rst_n = 1'b1;
        pin_pa = 8'h42;
        step();
        checks++;
        if (pin_pi !== 8'h00) begin
            failures++; $display("FAIL resetmid_ctrl got=%h exp=00", pin_pi);
        end
        repeat (20) step();
        checks++;
        if (pin_intr !== 1'b0 || pin_pi !== 8'h00) begin
            failures++; $display("FAIL resetmid_idle intr=%b pi=%h exp 0/00", pin_intr, pin_pi);
        end
    endtask

    initial begin
        test_reset();
        test_auto_reload();
        test_one_shot();
        test_hold_pw();
        test_ack_on_expiry();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
